tpu_mac_array: RTL and testbench
================================

# tpu_mac_array

Parametrised multiply-accumulate engine; successor to the single-pair 8x8 TPU functional unit. Accepts a stream of LANES operand pairs per beat, accumulates their dot product into a wide accumulator, and reports the result through a half-select output port with ready/error status. Sits between the operand feed logic and the result readback path of the TPU datapath.

## Interface
- DATA_W, 8, operand width per lane
- LANES, 4, operand pairs multiplied per beat
- ACC_W, 32, accumulator width; even; must be >= 2*DATA_W + clog2(LANES)
- OUT_W, ACC_W/2, readback width (derived, not overridable)
- clk  in  1  clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- sync  in  1  start-of-job pulse; clears accumulator and error
- signed_mode  in  1  1 = two's-complement operands; sampled only on accepted sync
- in_valid  in  1  operand beat valid
- in_last  in  1  marks final beat of job; meaningful only with in_valid
- input1  in  LANES*DATA_W  operand A, lane i at bits [i*DATA_W +: DATA_W]
- input2  in  LANES*DATA_W  operand B, same packing
- out_HL  in  1  0 = low half of accumulator, 1 = high half
- ready  out  1  job result valid
- error  out  1  sticky accumulator overflow flag
- out  out  OUT_W  selected accumulator half

## Operation
- States: IDLE, ACCUM, DONE. Reset -> IDLE, accumulator 0, pipeline valid 0, ready 0, error 0, out 0.
- sync=1 in any state: next state ACCUM, accumulator 0, error 0, ready 0, signed_mode latched, in-flight product stage discarded. sync has priority over in_valid in the same cycle (that beat is dropped).
- ACCUM: each cycle with in_valid=1 is one beat. Stage 1 registers LANES products (2*DATA_W each, signed or unsigned per latched mode). Stage 2 adds the lane sum, extended to ACC_W+1 bits, into the accumulator.
- in_valid with in_last=1 in ACCUM: no further beats accepted; state moves to DONE when that beat's accumulate completes.
- in_valid/in_last ignored in IDLE and DONE.
- Overflow: if the stage-2 sum leaves the ACC_W range (unsigned: > 2^ACC_W-1; signed: outside [-2^(ACC_W-1), 2^(ACC_W-1)-1]), accumulator saturates to the nearer bound and error sets. Once error=1, accumulator is frozen for the rest of the job.
- out = out_HL ? acc[ACC_W-1:OUT_W] : acc[OUT_W-1:0]; combinational mux on the registered accumulator, valid in every state (partial sums visible during ACCUM).
- DONE: ready=1, accumulator and error hold until next sync or reset.

## Timing
- Beat sampled at edge E0 -> product registered at E1 -> accumulator updated at E2.
- Last beat sampled at E0 -> ready=1 and state DONE from E2; out reflects the final value in the same cycle.
- Back-to-back beats: one beat per cycle, no bubbles required, no backpressure.
- error visible from the edge that writes the saturated value.
- sync to first accepted beat: beat may be presented in the cycle immediately after sync.
- reset asserted mid-job: all state cleared on that edge regardless of sync/in_valid.
- out_HL change: out changes in the same cycle (zero latency).

## Structure
- Shared package tpu_pkg: state encoding constants, lane-sum width function (2*DATA_W + clog2(LANES)), saturation bound helpers.
- Sub-module tpu_lane_mul: one per lane; registered DATA_W x DATA_W multiplier with signed/unsigned select and valid/flush input.
- Top: FSM, lane adder tree, saturating accumulator, output mux.

## Test plan
- Defaults, unsigned; input1 lane0=13, input2 lane0=15, other lanes 0, one beat with in_last -> ready high 2 cycles later; out_HL=0 gives 0x00C3, out_HL=1 gives 0x0000, error=0.
- Unsigned, 3 beats of all lanes A=2,B=3 -> 72 (0x0048); ready low until 2 cycles after third beat.
- signed_mode=1; lane0 A=0xFE (-2), B=3, one beat -> out_HL=0 0xFFFA, out_HL=1 0xFFFF.
- ACC_W=20, unsigned, all lanes 255x255, 5 beats -> after beat 5 accumulator 0xFFFFF, error=1; extra-beat-free DONE holds.
- sync asserted during ACCUM with in_valid=1 and a product in flight -> accumulator 0, error 0, dropped beat and in-flight product not summed.
- reset during ACCUM after 2 beats -> next cycle IDLE, out=0, ready=0, error=0; subsequent in_valid ignored until sync.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU multiply-accumulate array.
//   state_t    : job FSM encoding (IDLE / ACCUM / DONE)
//   sat_t      : saturation verdict for one accumulate step
//   lane_sum_w : width that holds the sum of LANES full-width products
//   sat_check  : classifies an ACC_W+1 bit sum against the ACC_W range
package tpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SAT_NONE = 2'd0,
        SAT_HI   = 2'd1,
        SAT_LO   = 2'd2
    } sat_t;

    function automatic int lane_sum_w(input int data_w, input int lanes);
        return 2 * data_w + $clog2(lanes);
    endfunction

    // The sum is one bit wider than the accumulator. Unsigned: the extra
    // bit is a carry out. Signed: the two top bits disagree only when the
    // result left the representable range, and the top bit gives the side.
    function automatic sat_t sat_check(input logic is_signed,
                                       input logic msb,
                                       input logic msb_m1);
        if (!is_signed)
            return msb ? SAT_HI : SAT_NONE;
        if (msb == msb_m1)
            return SAT_NONE;
        return msb ? SAT_LO : SAT_HI;
    endfunction

endpackage

// File: rtl/tpu_lane_mul.sv
// One lane of the MAC array: registered DATA_W x DATA_W multiplier.
// Operands are captured on an accepted beat, the product is registered on
// the following edge. flush drops everything in flight.
//   clk, reset  : clock, synchronous active-high reset
//   is_signed   : 1 = two's-complement operands
//   valid       : operand beat accepted this cycle
//   flush       : discard in-flight operands/product
//   a, b        : lane operands
//   prod        : registered 2*DATA_W product
//   prod_valid  : prod holds a live product
module tpu_lane_mul #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                is_signed,
    input  logic                valid,
    input  logic                flush,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [2*DATA_W-1:0] prod,
    output logic                prod_valid
);

    logic [DATA_W-1:0]   a_q, b_q;
    logic                op_valid;
    logic [2*DATA_W-1:0] a_ext, b_ext;

    // Extending both operands to the product width makes the low 2*DATA_W
    // bits of a plain multiply correct for either signedness.
    always_comb begin
        a_ext = {{DATA_W{1'b0}}, a_q};
        b_ext = {{DATA_W{1'b0}}, b_q};
        if (is_signed) begin
            a_ext = {{DATA_W{a_q[DATA_W-1]}}, a_q};
            b_ext = {{DATA_W{b_q[DATA_W-1]}}, b_q};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_valid   <= 1'b0;
            prod_valid <= 1'b0;
        end else begin
            op_valid   <= valid & ~flush;
            prod_valid <= op_valid & ~flush;
        end
    end

    // NOTE: data registers are not reset; the valid bits alone decide whether
    // their contents are ever consumed.
    always_ff @(posedge clk) begin
        if (valid) begin
            a_q <= a;
            b_q <= b;
        end
        if (op_valid)
            prod <= a_ext * b_ext;
    end

endmodule

// File: rtl/tpu_mac_array.sv
// Parametrised multiply-accumulate array. Each accepted beat carries LANES
// operand pairs; their dot product is summed into a saturating ACC_W-bit
// accumulator, readable one half at a time.
//   clk, reset    : clock, synchronous active-high reset
//   sync          : start of job; clears accumulator/error, latches mode
//   signed_mode   : operand signedness, sampled with sync
//   in_valid      : operand beat valid
//   in_last       : final beat of the job
//   input1/input2 : packed operands, lane i at [i*DATA_W +: DATA_W]
//   out_HL        : 0 = low half, 1 = high half of the accumulator
//   ready         : job result valid (DONE)
//   error         : sticky overflow flag
//   out           : selected accumulator half
module tpu_mac_array
    import tpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int ACC_W  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sync,
    input  logic                    signed_mode,
    input  logic                    in_valid,
    input  logic                    in_last,
    input  logic [LANES*DATA_W-1:0] input1,
    input  logic [LANES*DATA_W-1:0] input2,
    input  logic                    out_HL,
    output logic                    ready,
    output logic                    error,
    output logic [ACC_W/2-1:0]      out
);

    localparam int OUT_W = ACC_W / 2;
    localparam int SUM_W = lane_sum_w(DATA_W, LANES);

    state_t              state, state_next;
    logic [ACC_W-1:0]    acc, acc_next;
    logic                err_next;
    logic                mode_q;
    logic                closing, closing_next;
    logic                last_s1, last_s2;
    logic                accept, beat_valid;
    logic [2*DATA_W-1:0] prod [LANES];
    logic [LANES-1:0]    prod_vld;
    logic [SUM_W-1:0]    lane_sum;
    logic [ACC_W:0]      acc_ext, sum_ext, total;
    logic [ACC_W-1:0]    hi_bound, lo_bound;
    sat_t                sat;

    // Once the last beat is taken the job is closing: nothing more enters.
    assign accept     = (state == ACCUM) && !closing && in_valid && !sync;
    assign beat_valid = &prod_vld;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        tpu_lane_mul #(.DATA_W(DATA_W)) u_mul (
            .clk        (clk),
            .reset      (reset),
            .is_signed  (mode_q),
            .valid      (accept),
            .flush      (sync),
            .a          (input1[i*DATA_W +: DATA_W]),
            .b          (input2[i*DATA_W +: DATA_W]),
            .prod       (prod[i]),
            .prod_valid (prod_vld[i])
        );
    end

    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first, so no path can infer a latch.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            if (mode_q)
                lane_sum = lane_sum + SUM_W'($signed(prod[i]));
            else
                lane_sum = lane_sum + SUM_W'(prod[i]);
        end
    end

    always_comb begin
        if (mode_q) begin
            acc_ext  = {acc[ACC_W-1], acc};
            sum_ext  = (ACC_W+1)'($signed(lane_sum));
            hi_bound = {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            acc_ext  = {1'b0, acc};
            sum_ext  = (ACC_W+1)'(lane_sum);
            hi_bound = '1;
        end
        lo_bound = {1'b1, {(ACC_W-1){1'b0}}};
        total    = acc_ext + sum_ext;
        sat      = sat_check(mode_q, total[ACC_W], total[ACC_W-1]);
    end

    always_comb begin
        state_next   = state;
        acc_next     = acc;
        err_next     = error;
        closing_next = closing;
        if (sync) begin
            state_next   = ACCUM;
            acc_next     = '0;
            err_next     = 1'b0;
            closing_next = 1'b0;
        end else begin
            if (accept && in_last)
                closing_next = 1'b1;
            if (state == ACCUM && beat_valid) begin
                // After an overflow the saturated value stays put.
                if (!error) begin
                    case (sat)
                        SAT_HI: begin
                            acc_next = hi_bound;
                            err_next = 1'b1;
                        end
                        SAT_LO: begin
                            acc_next = lo_bound;
                            err_next = 1'b1;
                        end
                        default: acc_next = total[ACC_W-1:0];
                    endcase
                end
                if (last_s2)
                    state_next = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            acc     <= '0;
            error   <= 1'b0;
            mode_q  <= 1'b0;
            closing <= 1'b0;
            last_s1 <= 1'b0;
            last_s2 <= 1'b0;
        end else begin
            state   <= state_next;
            acc     <= acc_next;
            error   <= err_next;
            closing <= closing_next;
            if (sync)
                mode_q <= signed_mode;
            // The last flag travels alongside the lane valid bits.
            last_s1 <= accept & in_last;
            last_s2 <= last_s1 & ~sync;
        end
    end

    assign ready = (state == DONE);
    assign out   = out_HL ? acc[ACC_W-1:OUT_W] : acc[OUT_W-1:0];

endmodule

// File: tb/tb_tpu_mac_array.sv
module tb_tpu_mac_array;

    logic        clk = 1'b0;
    logic        reset, sync, signed_mode, in_valid, in_last, out_HL;
    logic [31:0] input1, input2;
    logic        ready, error, ready20, error20;
    logic [15:0] out;
    logic [9:0]  out20;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tpu_mac_array dut (
        .clk(clk), .reset(reset), .sync(sync), .signed_mode(signed_mode),
        .in_valid(in_valid), .in_last(in_last), .input1(input1), .input2(input2),
        .out_HL(out_HL), .ready(ready), .error(error), .out(out)
    );

    tpu_mac_array #(.ACC_W(20)) dut20 (
        .clk(clk), .reset(reset), .sync(sync), .signed_mode(signed_mode),
        .in_valid(in_valid), .in_last(in_last), .input1(input1), .input2(input2),
        .out_HL(out_HL), .ready(ready20), .error(error20), .out(out20)
    );

    typedef struct {
        logic        sgn;
        int          beats;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] lo;
        logic [15:0] hi;
    } vec_t;

    typedef struct {
        logic [15:0] lo;
        logic [15:0] hi;
        logic        err;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_job(input logic sgn);
        @(negedge clk);
        sync = 1'b1; signed_mode = sgn; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        sync = 1'b0;
    endtask

    task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic last);
        in_valid = 1'b1; in_last = last; input1 = a; input2 = b;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        while (!ready && lat < 8) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_pop(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            out_HL = 1'b0; #1;
            check({name, "_lo"}, 32'(out), 32'(e.lo));
            out_HL = 1'b1; #1;
            check({name, "_hi"}, 32'(out), 32'(e.hi));
            check({name, "_err"}, 32'(error), 32'(e.err));
            out_HL = 1'b0;
        end
    endtask

    task automatic check20(input string name, input logic [9:0] lo, input logic [9:0] hi,
                           input logic err);
        out_HL = 1'b0; #1;
        check({name, "_lo20"}, 32'(out20), 32'(lo));
        out_HL = 1'b1; #1;
        check({name, "_hi20"}, 32'(out20), 32'(hi));
        check({name, "_err20"}, 32'(error20), 32'(err));
        out_HL = 1'b0;
    endtask

    initial begin
        int lat;
        vecs[0] = '{1'b0, 1, 32'h0000_000D, 32'h0000_000F, 16'h00C3, 16'h0000};
        vecs[1] = '{1'b0, 3, 32'h0202_0202, 32'h0303_0303, 16'h0048, 16'h0000};
        vecs[2] = '{1'b1, 1, 32'h0000_00FE, 32'h0000_0003, 16'hFFFA, 16'hFFFF};
        vecs[3] = '{1'b1, 2, 32'h8080_8080, 32'h8080_8080, 16'h0000, 16'h0002};
        vecs[4] = '{1'b0, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'hF008, 16'h0007};
        vecs[5] = '{1'b1, 1, 32'h7F80_FF01, 32'h0180_0201, 16'h407E, 16'h0000};

        reset = 1'b1; sync = 1'b0; signed_mode = 1'b0; in_valid = 1'b0;
        in_last = 1'b0; out_HL = 1'b0; input1 = '0; input2 = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd0);
        sb.push_back('{16'h0000, 16'h0000, 1'b0});
        check_pop("rst");
        check20("rst", 10'h000, 10'h000, 1'b0);
        reset = 1'b0;

        // In IDLE, beats are ignored.
        beat(32'h0101_0101, 32'h0101_0101, 1'b1);
        repeat (3) @(negedge clk);
        check("idle_ignore", 32'(out), 32'd0);

        foreach (vecs[v]) begin
            start_job(vecs[v].sgn);
            sb.push_back('{vecs[v].lo, vecs[v].hi, 1'b0});
            for (int k = 0; k < vecs[v].beats; k++)
                beat(vecs[v].a, vecs[v].b, k == vecs[v].beats - 1);
            wait_ready(lat);
            check($sformatf("v%0d_lat", v), 32'(lat), 32'd2);
            check_pop($sformatf("v%0d", v));
            beat(vecs[v].a, vecs[v].b, 1'b1);
            repeat (2) @(negedge clk);
            #1;
            check($sformatf("v%0d_hold", v), 32'(out), 32'(vecs[v].lo));
            check($sformatf("v%0d_hold_rdy", v), 32'(ready), 32'd1);
        end

        // Unsigned overflow on the 20-bit accumulator.
        start_job(1'b0);
        sb.push_back('{16'hD814, 16'h0013, 1'b0});
        for (int k = 0; k < 5; k++)
            beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, k == 4);
        @(negedge clk);
        check20("ovf_b4", 10'h010, 10'h3F8, 1'b0);
        check("ovf_b4_rdy", 32'(ready20), 32'd0);
        @(negedge clk);
        check("ovf_rdy20", 32'(ready20), 32'd1);
        check("ovf_rdy", 32'(ready), 32'd1);
        check20("ovf", 10'h3FF, 10'h3FF, 1'b1);
        check_pop("ovf32");
        repeat (3) @(negedge clk);
        check20("ovf_hold", 10'h3FF, 10'h3FF, 1'b1);
        check("ovf_hold_rdy", 32'(ready20), 32'd1);

        // Signed saturation, then a negative beat must not move the value.
        start_job(1'b1);
        sb.push_back('{16'h0200, 16'h0007, 1'b0});
        for (int k = 0; k < 8; k++)
            beat(32'h8080_8080, 32'h8080_8080, 1'b0);
        beat(32'h8080_8080, 32'h7F7F_7F7F, 1'b1);
        wait_ready(lat);
        check("frz_lat", 32'(lat), 32'd2);
        check_pop("frz32");
        check20("frz", 10'h3FF, 10'h1FF, 1'b1);

        // sync mid-job with a beat presented and products in flight.
        start_job(1'b0);
        beat(32'h0000_000A, 32'h0000_000A, 1'b0);
        beat(32'h0000_0014, 32'h0000_000A, 1'b0);
        beat(32'h0000_001E, 32'h0000_000A, 1'b0);
        check("partial", 32'(out), 32'd100);
        sync = 1'b1; signed_mode = 1'b0; in_valid = 1'b1; in_last = 1'b0;
        input1 = 32'hFFFF_FFFF; input2 = 32'hFFFF_FFFF;
        @(negedge clk);
        sync = 1'b0; in_valid = 1'b0;
        check("sync_acc", 32'(out), 32'd0);
        check("sync_err", 32'(error), 32'd0);
        check("sync_rdy", 32'(ready), 32'd0);
        check20("sync", 10'h000, 10'h000, 1'b0);
        sb.push_back('{16'h0019, 16'h0000, 1'b0});
        beat(32'h0000_0005, 32'h0000_0005, 1'b1);
        check("flush_p5", 32'(out), 32'd0);
        wait_ready(lat);
        check("sync_lat", 32'(lat), 32'd2);
        check_pop("sync_job");
        check20("sync_job", 10'h019, 10'h000, 1'b0);

        // reset mid-job; later beats ignored until sync.
        start_job(1'b0);
        beat(32'h0101_0101, 32'h0101_0101, 1'b0);
        beat(32'h0101_0101, 32'h0101_0101, 1'b0);
        reset = 1'b1; in_valid = 1'b1; in_last = 1'b0;
        @(negedge clk);
        reset = 1'b0; in_last = 1'b1;
        check("rstmid_rdy", 32'(ready), 32'd0);
        sb.push_back('{16'h0000, 16'h0000, 1'b0});
        check_pop("rstmid");
        repeat (4) @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        check("rstmid_ign_out", 32'(out), 32'd0);
        check("rstmid_ign_rdy", 32'(ready), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
